// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the P6 fetch-side blocks.
//   RESET_PC    : PC value loaded by the PC register on reset
//   TEXT_BASE   : lowest legal fetch address
//   TEXT_END    : highest legal fetch address
//   fetch_entry_t : one captured fetch {pc, instr, exc}
//   fq_state_t    : fetch queue control state (RUN / HALT)
//   fetch_addr_err: address-error rule for a fetch PC against a text window
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
  localparam logic [31:0] TEXT_END  = 32'h0000_4FFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fq_state_t;

  // A fetch is bad when misaligned or outside [base, last].
  function automatic logic fetch_addr_err(input logic [31:0] pc,
                                          input logic [31:0] base,
                                          input logic [31:0] last);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > last);
  endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// fetch_fifo_mem: entry storage for the fetch queue.
//   clk     : clock, write on rising edge
//   we      : write enable (push)
//   wr_ptr  : tail slot written when we=1
//   wr_data : entry written at the tail
//   rd_ptr  : head slot
//   rd_data : entry at the head, combinational read
// The data array carries no reset: occupancy is tracked by the top, and
// stale slots are never presented because the top masks the head output.
module fetch_fifo_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  fetch_entry_t             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output fetch_entry_t             rd_data
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling buffer between IF (PC register + instruction
// memory) and ID of the P6 MIPS32 pipeline.
//   clk       : clock
//   reset     : asynchronous active-low reset
//   pc_f      : current PC from the PC register
//   instr_f   : instruction memory read data for pc_f (same cycle)
//   flush     : redirect; drops all queued and in-flight fetches
//   pc_en     : PC register enable (advance, or load redirect on flush)
//   d_valid   : head entry valid to decode
//   d_ready   : decode accepts the head entry
//   d_pc      : head entry PC (0 when d_valid=0)
//   d_instr   : head entry instruction (0 when d_valid=0)
//   d_exc     : head entry fetch address error (0 when d_valid=0)
//   count     : occupied entries
//   fsm_state : control state, exposed for observation
//
// Handshake: an entry moves to decode in a cycle where d_valid and d_ready
// are both high at the rising edge. d_valid never depends on d_ready, and
// the head entry holds stable while d_valid=1 and d_ready=0 (unless flush
// or reset discards it). The fetch side has no valid: pc_en is its ready,
// and the {pc_f, instr_f} pair is captured on every edge where pc_en=1 and
// flush=0.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] TEXT_BASE = cpu_pkg::TEXT_BASE,
  parameter logic [31:0] TEXT_END  = cpu_pkg::TEXT_END
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                pc_f,
  input  logic [31:0]                instr_f,
  input  logic                       flush,
  output logic                       pc_en,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [31:0]                d_pc,
  output logic [31:0]                d_instr,
  output logic                       d_exc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fq_state_t                  fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count_q;
  fq_state_t     state;

  logic          exc_f;
  logic          pop;
  logic          push;
  logic          not_full;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;

  // ---------------------------------------------------------------------
  // Handshake and fetch acceptance
  // ---------------------------------------------------------------------
  assign exc_f    = fetch_addr_err(pc_f, TEXT_BASE, TEXT_END);
  assign d_valid  = (count_q != '0);
  assign pop      = d_valid & d_ready;
  assign not_full = (count_q < CW'(DEPTH));

  // A full queue still accepts a fetch when the head leaves the same cycle,
  // which is what sustains one fetch per cycle at full occupancy.
  assign push = ~flush & (state == ST_RUN) & (not_full | pop);

  // On flush the PC register must load the redirect target, so the enable
  // is raised even though nothing is captured. Held low throughout reset.
  assign pc_en = reset & (flush | push);

  assign wr_entry = '{pc: pc_f, instr: instr_f, exc: exc_f};

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  fetch_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_ptr  (tail_ptr),
    .wr_data (wr_entry),
    .rd_ptr  (head_ptr),
    .rd_data (head_entry)
  );

  // ---------------------------------------------------------------------
  // Pointers, occupancy and control state
  // ---------------------------------------------------------------------
  // Flush wins over any same-cycle push or pop: a head accepted by decode
  // in the flush cycle is simply dropped along with everything else.
  // After an errored fetch is captured, fetch stops (HALT) so no further
  // wrong-path addresses are requested; queued entries keep draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      state    <= ST_RUN;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      state    <= ST_RUN;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) begin
        tail_ptr <= tail_ptr + PW'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push && exc_f) begin
        state <= ST_HALT;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: head fields are forced to zero while the queue is empty so
  // decode never sees stale array contents.
  // ---------------------------------------------------------------------
  assign d_pc      = d_valid ? head_entry.pc    : 32'h0;
  assign d_instr   = d_valid ? head_entry.instr : 32'h0;
  assign d_exc     = d_valid ? head_entry.exc   : 1'b0;
  assign count     = count_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue (DEPTH=2).
// The bench plays the PC register and instruction memory, and predicts
// every output from a queue-based reference model of the buffer.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int W     = 65;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc_f = 32'h0;
  logic [31:0] instr_f = 32'h0;
  logic        flush = 1'b0;
  logic        pc_en;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_exc;
  logic [1:0]  count;
  fq_state_t   fsm_state;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .pc_f      (pc_f),
    .instr_f   (instr_f),
    .flush     (flush),
    .pc_en     (pc_en),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_pc      (d_pc),
    .d_instr   (d_instr),
    .d_exc     (d_exc),
    .count     (count),
    .fsm_state (fsm_state)
  );

  // -------------------------------------------------------------------
  // Scoreboard / reference model
  // -------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic         halted = 1'b0;
  logic [31:0]  pc = RESET_PC;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h0000_3000) || (a > 32'h0000_4FFC);
  endfunction

  // One cycle: drive inputs, check outputs against the model, advance the
  // model and the bench's PC register, then move past the next edge.
  task automatic step(input logic rdy, input logic fl, input logic [31:0] tgt);
    logic         e_valid, e_pop, e_push, e_pc_en;
    logic [W-1:0] head;
    d_ready = rdy;
    flush   = fl;
    pc_f    = pc;
    instr_f = imem(pc);
    #1;
    e_valid = (exp_q.size() != 0);
    head    = e_valid ? exp_q[0] : '0;
    e_pop   = e_valid && rdy;
    e_push  = !fl && !halted && ((exp_q.size() < DEPTH) || e_pop);
    e_pc_en = fl || e_push;
    check("d_valid", 64'(d_valid), 64'(e_valid));
    check("d_pc", 64'(d_pc), 64'(head[64:33]));
    check("d_instr", 64'(d_instr), 64'(head[32:1]));
    check("d_exc", 64'(d_exc), 64'(head[0]));
    check("count", 64'(count), 64'(exp_q.size()));
    check("pc_en", 64'(pc_en), 64'(e_pc_en));
    check("halt", 64'(fsm_state == ST_HALT), 64'(halted));
    if (fl) begin
      exp_q.delete();
      halted = 1'b0;
    end else begin
      if (e_pop) void'(exp_q.pop_front());
      if (e_push) begin
        exp_q.push_back({pc, imem(pc), addr_bad(pc)});
        if (addr_bad(pc)) halted = 1'b1;
      end
    end
    if (e_pc_en) pc = fl ? tgt : pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 6))
      0: return 32'h0000_3000;
      1: return 32'h0000_4FF8;
      2: return 32'h0000_5000;
      3: return 32'h0000_2FFC;
      4: return 32'h0000_3002;
      default: return 32'h0000_3000 + {18'b0, 12'($urandom_range(0, 4095)), 2'b00} % 32'h2000;
    endcase
  endfunction

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    pc_f = RESET_PC;
    instr_f = imem(RESET_PC);
    #1;
    check("rst_d_valid", 64'(d_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_d_pc", 64'(d_pc), 64'd0);
    check("rst_d_instr", 64'(d_instr), 64'd0);
    check("rst_d_exc", 64'(d_exc), 64'd0);
    check("rst_pc_en", 64'(pc_en), 64'd0);
    check("rst_state", 64'(fsm_state == ST_HALT), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming with decode always ready
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Redirect to empty, then back-pressure for 4 cycles
    step(1'b1, 1'b1, 32'h0000_3100);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    // Drain with simultaneous push/pop while full (pointer wrap)
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Fill again, then flush with d_ready=1 and count=2
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_3200);
    repeat (3) step(1'b1, 1'b0, 32'h0);

    // Address errors: misaligned, above and below the text window
    step(1'b0, 1'b1, 32'h0000_3002);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_5000);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_2FFC);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    // Last legal word, then the next fetch runs off the end
    step(1'b1, 1'b1, 32'h0000_4FFC);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Randomized traffic
    step(1'b1, 1'b1, 32'h0000_3000);
    for (int i = 0; i < 400; i++) begin
      step(1'b0 + ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), pick_target());
    end

    // Asynchronous reset with a full queue
    step(1'b1, 1'b1, 32'h0000_3400);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    check("pre_areset_count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_d_valid", 64'(d_valid), 64'd0);
    check("areset_count", 64'(count), 64'd0);
    check("areset_d_pc", 64'(d_pc), 64'd0);
    check("areset_pc_en", 64'(pc_en), 64'd0);
    exp_q.delete();
    halted = 1'b0;
    pc = RESET_PC;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

- Fetch-side decoupling buffer between the PC register / instruction memory (IF) and the decode stage (ID) of the P6 pipelined MIPS32 core.
- Captures each fetched {PC, instruction} pair into a small FIFO and presents entries to decode with a valid/ready handshake.
- Drives the PC register's enable (back-pressure) and tags fetch address errors.
- Halts fetch after an errored fetch until a redirect.

## Interface

Parameters:
- DEPTH, 2: queue entries; power of two, ≥2
- TEXT_BASE, 32'h0000_3000: lowest legal fetch address
- TEXT_END, 32'h0000_4FFC: highest legal fetch address

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- pc_f  in  32  current PC from the PC register
- instr_f  in  32  instruction memory read data for pc_f (combinational, same cycle)
- flush  in  1  redirect (branch/jump/exception); discards all queued and in-flight fetches
- pc_en  out  1  enable to PC register; high = PC advances/loads this cycle
- d_valid  out  1  head entry valid to decode
- d_ready  in  1  decode accepts head entry
- d_pc  out  32  head entry PC (0 when d_valid=0)
- d_instr  out  32  head entry instruction (0 when d_valid=0)
- d_exc  out  1  head entry fetch address error (0 when d_valid=0)
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation

- pop = d_valid & d_ready; push = ~flush & (state==RUN) & (count<DEPTH | pop).
- pc_en = reset_deasserted & (flush | push). The PC loads the redirect target on flush.
- exc_f = (pc_f[1:0]!=0) | (pc_f<TEXT_BASE) | (pc_f>TEXT_END); pushed with the entry.
- States:
  - RUN: normal fetch.
  - RUN→HALT: on a push with exc_f=1 and no flush.
  - HALT: push=0, pc_en=0 (unless flush); queued entries still drain to decode.
  - HALT→RUN: on flush.
- flush: count←0, head/tail pointers←0, state←RUN. Flush overrides pop and push in the same cycle. A simultaneous d_ready handshake is discarded; the flush source owns correctness.
- Simultaneous push & pop when full: allowed; count unchanged.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH or drops below 0.
- Arithmetic: count update = count + push − pop, unsigned, width $clog2(DEPTH+1).

## Timing

- Reset values: count=0, d_valid=0, d_pc=0, d_instr=0, d_exc=0, state=RUN, pointers=0. pc_en=0 while reset is low.
- Latency: a fetch pushed in cycle N into an empty queue gives d_valid=1 with that entry in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- Back-pressure: when count==DEPTH and d_ready=0, pc_en=0 and pc_f holds; instr_f is re-sampled on a later cycle.
- After flush in cycle N: d_valid=0 in N+1. The first redirected entry appears in N+2.
- Reset asserted mid-operation: all state clears immediately (asynchronously). First push is the first rising edge after deassertion.

## Structure

- Shared package cpu_pkg holds:
  - constants RESET_PC (32'h0000_3000), TEXT_BASE, TEXT_END
  - struct fetch_entry_t {pc[31:0], instr[31:0], exc}
- Sub-module fetch_fifo_mem: DEPTH×fetch_entry_t register array with write-at-tail, combinational read-at-head; no reset on the data array.
- Pointer/count/state logic and handshake in the top.

## Test plan

- Reset then streaming with d_ready=1: pc_f 0x3000, 0x3004, 0x3008 -> d_pc sequence identical, one cycle later; pc_en=1 every cycle; count≤1.
- Back-pressure with d_ready=0 for 4 cycles from empty -> count 1, 2, 2, 2; pc_en 1, 1, 0, 0. Then d_ready=1 -> entries drain in order with no loss or duplication.
- Full with simultaneous push/pop (count=2, d_ready=1) -> count stays 2; pc_en=1; FIFO order preserved across pointer wrap.
- flush with count=2 and d_ready=1 -> count=0 and d_valid=0 next cycle; the popped head is not counted; the first entry after flush has the redirected pc_f.
- pc_f=0x3002 -> entry has d_exc=1; state HALT; pc_en=0 until flush; 0x5000 and 0x2FFC also flag exc; 0x4FFC does not.
- reset driven low while count=2 -> d_valid, count and d_pc go to 0 asynchronously, before the next clk edge.
